// File: rtl/frame_buf_if.sv
// Bus bundle between the frame buffer controller, the pixel writer/reader
// and the external single-port frame memory.
//   writer : wr_en_in, data_in -> wr_ready
//   reader : rd_en_in -> rd_ready, rd_valid, data_out
//   memory : mem_addr, mem_wr_en, mem_rd_en, mem_wdata -> mem_rdata
//   status : frame_swap, frame_valid
// slave = controller side, master = environment (video stages + memory).
interface frame_buf_if #(
   parameter int unsigned DATA_WIDTH     = 24,
   parameter int unsigned PIX_ADDR_WIDTH = 10
);
   logic                      wr_en_in;
   logic [DATA_WIDTH-1:0]     data_in;
   logic                      wr_ready;
   logic                      rd_en_in;
   logic                      rd_ready;
   logic                      rd_valid;
   logic [DATA_WIDTH-1:0]     data_out;
   logic [PIX_ADDR_WIDTH:0]   mem_addr;
   logic                      mem_wr_en;
   logic                      mem_rd_en;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic                      frame_swap;
   logic                      frame_valid;

   modport slave (
      input  wr_en_in, data_in, rd_en_in, mem_rdata,
      output wr_ready, rd_ready, rd_valid, data_out,
             mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
             frame_swap, frame_valid
   );

   modport master (
      output wr_en_in, data_in, rd_en_in, mem_rdata,
      input  wr_ready, rd_ready, rd_valid, data_out,
             mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
             frame_swap, frame_valid
   );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer controller for a single-port frame memory.
// Arbitrates one access per cycle between a pixel writer and a pixel reader,
// builds {bank, pixel} memory addresses and swaps banks at frame boundaries
// once the write frame is complete and the read frame is fully consumed.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : frame_buf_if.slave (writer, reader, memory and status signals)
// Grants, memory strobes, mem_addr and frame_swap are combinational;
// rd_valid, data_out and frame_valid are registered.
module frame_buf_ctrl #(
   parameter int unsigned DATA_WIDTH     = 24,
   parameter int unsigned PIX_ADDR_WIDTH = 10,
   parameter int unsigned FRAME_PIXELS   = 1024
) (
   input  logic       clk,
   input  logic       reset,
   frame_buf_if.slave bus
);
   localparam int unsigned CNT_WIDTH = PIX_ADDR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] FRAME_CNT = CNT_WIDTH'(FRAME_PIXELS);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_SWAP} state_t;
   typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

   state_t                 state, state_nxt;
   grant_t                 last_grant;
   logic                   wr_bank;
   logic [CNT_WIDTH-1:0]   wr_cnt, rd_cnt;
   logic                   rd_pipe;
   logic                   rd_valid_q;
   logic [DATA_WIDTH-1:0]  data_out_q;
   logic                   frame_valid_q;

   logic wr_elig, rd_elig, wr_req, rd_req, wr_gnt, rd_gnt;
   logic wr_done, rd_done;

   // Eligibility, round-robin arbitration and next-state decode
   always_comb begin
      state_nxt = state;
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      wr_elig   = (state != S_SWAP) && (wr_cnt < FRAME_CNT);
      rd_elig   = (state == S_RUN) && (rd_cnt < FRAME_CNT);
      wr_req    = bus.wr_en_in && wr_elig && !reset;
      rd_req    = bus.rd_en_in && rd_elig && !reset;

      if (wr_req && rd_req) begin
         if (last_grant == GRANT_READ) wr_gnt = 1'b1;
         else                          rd_gnt = 1'b1;
      end else begin
         wr_gnt = wr_req;
         rd_gnt = rd_req;
      end

      // Frame completion looks at the post-grant count so the swap lands
      // in the cycle right after the last transfer
      wr_done = (wr_cnt + CNT_WIDTH'(wr_gnt)) == FRAME_CNT;
      rd_done = (rd_cnt + CNT_WIDTH'(rd_gnt)) == FRAME_CNT;

      case (state)
         S_INIT:  if (wr_done) state_nxt = S_SWAP;
         S_RUN:   if (wr_done && rd_done) state_nxt = S_SWAP;
         S_SWAP:  state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   // State register, counters, bank and read-valid pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_INIT;
         last_grant    <= GRANT_READ;
         wr_bank       <= 1'b0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         rd_pipe       <= 1'b0;
         rd_valid_q    <= 1'b0;
         data_out_q    <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_SWAP) begin
            wr_bank       <= ~wr_bank;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            frame_valid_q <= 1'b1;
         end else begin
            if (wr_gnt) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (rd_gnt) rd_cnt <= rd_cnt + CNT_WIDTH'(1);
         end
         if (wr_gnt || rd_gnt) last_grant <= wr_gnt ? GRANT_WRITE : GRANT_READ;
         // Memory returns data one cycle after the strobe; capture it the
         // cycle after that, independent of any bank swap in between
         rd_pipe    <= rd_gnt;
         rd_valid_q <= rd_pipe;
         if (rd_pipe) data_out_q <= bus.mem_rdata;
      end
   end

   assign bus.wr_ready    = wr_gnt;
   assign bus.rd_ready    = rd_gnt;
   assign bus.mem_wr_en   = wr_gnt;
   assign bus.mem_rd_en   = rd_gnt;
   assign bus.mem_wdata   = bus.data_in;
   // Reader always addresses the bank the writer is not filling
   assign bus.mem_addr    = wr_gnt ? {wr_bank,  wr_cnt[PIX_ADDR_WIDTH-1:0]} :
                            rd_gnt ? {~wr_bank, rd_cnt[PIX_ADDR_WIDTH-1:0]} :
                                     '0;
   assign bus.frame_swap  = (state == S_SWAP) && !reset;
   assign bus.frame_valid = frame_valid_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.data_out    = data_out_q;
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with FRAME_PIXELS=4, PIX_ADDR_WIDTH=2.
// Includes a behavioural single-port memory with one-cycle read latency.
module tb_frame_buf_ctrl;
   localparam int unsigned DW  = 8;
   localparam int unsigned PAW = 2;
   localparam int unsigned FP  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   frame_buf_if #(.DATA_WIDTH(DW), .PIX_ADDR_WIDTH(PAW)) bus ();

   frame_buf_ctrl #(
      .DATA_WIDTH(DW), .PIX_ADDR_WIDTH(PAW), .FRAME_PIXELS(FP)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Frame memory model: write on strobe, read data valid next cycle
   logic [DW-1:0] mem [0:7];
   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant/strobe/address check for the current cycle
   task automatic gchk(input string tag, input logic w, input logic r, input logic [2:0] a);
      chk({tag, ".wr_ready"},  32'(bus.wr_ready),  32'(w));
      chk({tag, ".rd_ready"},  32'(bus.rd_ready),  32'(r));
      chk({tag, ".mem_wr_en"}, 32'(bus.mem_wr_en), 32'(w));
      chk({tag, ".mem_rd_en"}, 32'(bus.mem_rd_en), 32'(r));
      chk({tag, ".mem_addr"},  32'(bus.mem_addr),  32'(a));
   endtask

   // Read-return check for the current cycle
   task automatic ochk(input string tag, input logic v, input logic [DW-1:0] d);
      chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(v));
      if (v) chk({tag, ".data_out"}, 32'(bus.data_out), 32'(d));
   endtask

   // Advance one cycle and apply inputs shortly after the edge
   task automatic cyc(input logic r, input logic we, input logic [DW-1:0] d, input logic re);
      @(posedge clk);
      #1;
      reset        = r;
      bus.wr_en_in = we;
      bus.data_in  = d;
      bus.rd_en_in = re;
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      bus.wr_en_in = 1'b0;
      bus.data_in  = '0;
      bus.rd_en_in = 1'b0;

      // Reset: requests are ignored while reset is high
      cyc(1, 0, 0, 0);
      cyc(1, 1, 7, 1);
      gchk("rst", 0, 0, 0);
      chk("rst.frame_swap", 32'(bus.frame_swap), 32'd0);

      // First fill into bank 0; reader requests but is held off in INIT
      cyc(0, 1, 1, 1);
      chk("c1.rd_valid",    32'(bus.rd_valid),    32'd0);
      chk("c1.data_out",    32'(bus.data_out),    32'd0);
      chk("c1.frame_valid", 32'(bus.frame_valid), 32'd0);
      gchk("c1", 1, 0, 0);
      chk("c1.mem_wdata",   32'(bus.mem_wdata),   32'd1);
      cyc(0, 1, 2, 1); gchk("c2", 1, 0, 1);
      cyc(0, 1, 3, 1); gchk("c3", 1, 0, 2);
      cyc(0, 1, 4, 1); gchk("c4", 1, 0, 3);
      cyc(0, 1, 5, 1); gchk("c5", 0, 0, 0);
      chk("c5.frame_swap",  32'(bus.frame_swap),  32'd1);
      chk("c5.frame_valid", 32'(bus.frame_valid), 32'd0);

      // Bank 1 written while bank 0 is read; grants alternate
      cyc(0, 0, 5, 1); gchk("c6", 0, 1, 0);
      chk("c6.frame_valid", 32'(bus.frame_valid), 32'd1);
      chk("c6.frame_swap",  32'(bus.frame_swap),  32'd0);
      cyc(0, 1, 5, 1); gchk("c7", 1, 0, 4); ochk("c7", 0, 0);
      chk("c7.mem_wdata",   32'(bus.mem_wdata),   32'd5);
      cyc(0, 1, 6, 1); gchk("c8", 0, 1, 1); ochk("c8", 1, 1);
      cyc(0, 1, 6, 1); gchk("c9", 1, 0, 5); ochk("c9", 0, 0);
      cyc(0, 1, 7, 1); gchk("c10", 0, 1, 2); ochk("c10", 1, 2);
      cyc(0, 1, 7, 1); gchk("c11", 1, 0, 6);
      cyc(0, 1, 8, 1); gchk("c12", 0, 1, 3); ochk("c12", 1, 3);
      cyc(0, 1, 8, 1); gchk("c13", 1, 0, 7);
      // Swap with the last read still in flight
      cyc(0, 1, 9, 1); gchk("c14", 0, 0, 0); ochk("c14", 1, 4);
      chk("c14.frame_swap", 32'(bus.frame_swap), 32'd1);

      // Writer finishes first while reader pauses after 2 reads
      cyc(0, 1, 9, 1);  gchk("c15", 0, 1, 4); ochk("c15", 0, 0);
      cyc(0, 1, 9, 1);  gchk("c16", 1, 0, 0);
      chk("c16.mem_wdata", 32'(bus.mem_wdata), 32'd9);
      cyc(0, 1, 10, 1); gchk("c17", 0, 1, 5); ochk("c17", 1, 5);
      cyc(0, 1, 10, 0); gchk("c18", 1, 0, 1);
      cyc(0, 1, 11, 0); gchk("c19", 1, 0, 2); ochk("c19", 1, 6);
      cyc(0, 1, 12, 0); gchk("c20", 1, 0, 3);
      cyc(0, 1, 13, 0); gchk("c21", 0, 0, 0);
      chk("c21.frame_swap", 32'(bus.frame_swap), 32'd0);
      cyc(0, 1, 13, 1); gchk("c22", 0, 1, 6);
      cyc(0, 1, 13, 1); gchk("c23", 0, 1, 7);
      cyc(0, 1, 13, 1); gchk("c24", 0, 0, 0); ochk("c24", 1, 7);
      chk("c24.frame_swap", 32'(bus.frame_swap), 32'd1);

      // Reader finishes first while writer is mid-frame
      cyc(0, 1, 13, 1); gchk("c25", 1, 0, 4); ochk("c25", 1, 8);
      cyc(0, 1, 14, 1); gchk("c26", 0, 1, 0);
      cyc(0, 1, 14, 1); gchk("c27", 1, 0, 5);
      cyc(0, 0, 14, 1); gchk("c28", 0, 1, 1); ochk("c28", 1, 9);
      cyc(0, 0, 14, 1); gchk("c29", 0, 1, 2); ochk("c29", 0, 0);
      cyc(0, 0, 14, 1); gchk("c30", 0, 1, 3); ochk("c30", 1, 10);
      cyc(0, 0, 14, 1); gchk("c31", 0, 0, 0); ochk("c31", 1, 11);
      cyc(0, 1, 15, 1); gchk("c32", 1, 0, 6); ochk("c32", 1, 12);
      cyc(0, 1, 16, 1); gchk("c33", 1, 0, 7);
      chk("c33.frame_swap", 32'(bus.frame_swap), 32'd0);
      cyc(0, 1, 17, 1); gchk("c34", 0, 0, 0);
      chk("c34.frame_swap",  32'(bus.frame_swap),  32'd1);
      chk("c34.frame_valid", 32'(bus.frame_valid), 32'd1);

      // Reset mid-frame with a read in flight
      cyc(0, 0, 17, 1); gchk("c35", 0, 1, 4);
      cyc(1, 1, 17, 1); gchk("c36", 0, 0, 0);
      chk("c36.frame_swap", 32'(bus.frame_swap), 32'd0);
      cyc(0, 1, 20, 0);
      ochk("c37", 0, 0);
      chk("c37.data_out",    32'(bus.data_out),    32'd0);
      chk("c37.frame_valid", 32'(bus.frame_valid), 32'd0);
      gchk("c37", 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
